// File: rtl/ram_bist_pkg.sv
// ============================================================================
// Module   : ram_bist_pkg
// Brief    : Shared state encoding and default pattern seed for ram_bist.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ram_bist_pkg;

  localparam int unsigned C_SEED_DEFAULT = 32'h5A;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W0    = 3'd1,
    S_R0    = 3'd2,
    S_W1    = 3'd3,
    S_R1    = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_bist_if.sv
// ============================================================================
// Module   : ram_bist_if
// Brief    : Single-port RAM bus between the BIST initiator and one RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ram_bist_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic [AW-1:0] a;
  logic [DW-1:0] din;
  logic          we;
  logic [DW-1:0] dout;

  modport master (output a, output din, output we, input dout);
  modport slave  (input a, input din, input we, output dout);
endinterface

`default_nettype wire

// File: rtl/ram_bist_chk.sv
// ============================================================================
// Module   : ram_bist_chk
// Brief    : Read-check pipeline, comparator and first-failure capture.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_bist_chk #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          i_clr,
  input  wire logic          i_rd,
  input  wire logic [DW-1:0] i_exp,
  input  wire logic [AW-1:0] i_a,
  input  wire logic [DW-1:0] i_dout,
  output logic               o_mismatch,
  output logic               o_fail,
  output logic [AW-1:0]      o_fail_addr,
  output logic [DW-1:0]      o_fail_data
);

  logic          r_chk;
  logic [DW-1:0] r_exp;
  logic [AW-1:0] r_exp_a;
  logic          r_fail;
  logic [AW-1:0] r_fail_addr;
  logic [DW-1:0] r_fail_data;

  // RAM output is registered, so the expectation is delayed one edge to line up with dout
  assign o_mismatch = r_chk && (i_dout != r_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk       <= 1'b0;
      r_exp       <= '0;
      r_exp_a     <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_chk   <= i_rd;
      r_exp   <= i_exp;
      r_exp_a <= i_a;
      if (i_clr) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else if (o_mismatch) begin
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_fail_addr <= r_exp_a;
          r_fail_data <= i_dout;
        end
      end
    end
  end

  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;

endmodule

`default_nettype wire

// File: rtl/ram_bist.sv
// ============================================================================
// Module   : ram_bist
// Brief    : Four-phase march BIST for a single-port RAM (W0,R0,W1,R1,FLUSH).
//            RAM_BIST_STOP_ON_FAIL_EN: abort to IDLE on the first mismatch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int          AW   = 5,
  parameter int          DW   = 8,
  parameter int unsigned SEED = C_SEED_DEFAULT
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  input  wire logic     i_start,
  ram_bist_if.master    ram,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_fail,
  output logic [AW-1:0] o_fail_addr,
  output logic [DW-1:0] o_fail_data
);

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  localparam bit C_STOP = 1'b1;
`else
  localparam bit C_STOP = 1'b0;
`endif

  localparam logic [DW-1:0] C_SEED = DW'(SEED);

  function automatic logic [DW-1:0] f_pattern(input logic [AW-1:0] x);
    logic [DW-1:0] xe;
    xe = DW'(x);
    return xe ^ C_SEED;
  endfunction

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_a, w_a_nxt;
  logic          r_busy, r_done;
  logic          w_we, w_rd, w_last, w_accept, w_mismatch;
  logic [DW-1:0] w_din, w_exp, w_pat;

  assign w_pat    = f_pattern(r_a);
  assign w_last   = &r_a;
  assign w_accept = (r_state == S_IDLE) && i_start;

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = '0;
    w_we        = 1'b0;
    w_rd        = 1'b0;
    w_din       = '0;
    w_exp       = '0;
    unique case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_W0;
      S_W0: begin
        w_we    = 1'b1;
        w_din   = w_pat;
        w_a_nxt = r_a + AW'(1);
        if (w_last) w_state_nxt = S_R0;
      end
      S_R0: begin
        w_rd    = 1'b1;
        w_exp   = w_pat;
        w_a_nxt = r_a + AW'(1);
        if (w_last) w_state_nxt = S_W1;
      end
      S_W1: begin
        w_we    = 1'b1;
        w_din   = ~w_pat;
        w_a_nxt = r_a + AW'(1);
        if (w_last) w_state_nxt = S_R1;
      end
      S_R1: begin
        w_rd    = 1'b1;
        w_exp   = ~w_pat;
        w_a_nxt = r_a + AW'(1);
        if (w_last) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Early abort only redirects the next state; we/din stay purely state-decoded
    if (C_STOP && w_mismatch && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_a_nxt     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if ((r_state != S_IDLE) && (w_state_nxt == S_IDLE)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  ram_bist_chk #(
    .AW (AW),
    .DW (DW)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_accept),
    .i_rd        (w_rd),
    .i_exp       (w_exp),
    .i_a         (r_a),
    .i_dout      (ram.dout),
    .o_mismatch  (w_mismatch),
    .o_fail      (o_fail),
    .o_fail_addr (o_fail_addr),
    .o_fail_data (o_fail_data)
  );

  assign ram.a   = r_a;
  assign ram.din = w_din;
  assign ram.we  = w_we;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_bist.sv
// ============================================================================
// Module   : tb_ram_bist
// Brief    : Self-checking bench for ram_bist with a fault-injectable RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_bist;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 1 << AW;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned k = 0;

  ram_bist_if #(.AW(AW), .DW(DW)) ram_bus ();

  ram_bist #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .ram         (ram_bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_fail      (fail),
    .o_fail_addr (fail_addr),
    .o_fail_data (fail_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port synchronous RAM; a stuck bit corrupts the read path of one word
  logic [DW-1:0] mem [N];
  bit            wf_mode = 1'b0;
  bit            f_en = 1'b0;
  bit            f_pol = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_mask = '0;

  always @(posedge clk) begin
    logic [DW-1:0] rd;
    rd = mem[ram_bus.a];
    if (f_en && ram_bus.a == f_addr) rd = f_pol ? (rd | f_mask) : (rd & ~f_mask);
    if (ram_bus.we) begin
      mem[ram_bus.a] <= ram_bus.din;
      if (wf_mode) rd = ram_bus.din;
    end
    ram_bus.dout <= rd;
  end

  function automatic logic [DW-1:0] pat(input int x);
    return DW'(x) ^ 8'h5A;
  endfunction

  // Reference: walk the march over an array, first mismatch decides fail/addr/data/latency
  task automatic model(input bit fe, input int fa, input logic [DW-1:0] fm, input bit fp,
                       output bit e_fail, output int e_addr, output int e_data, output int e_lat);
    logic [DW-1:0] m [N];
    logic [DW-1:0] rd, ex;
    e_fail = 1'b0; e_addr = 0; e_data = 0; e_lat = 4 * N + 1;
    for (int p = 0; p < 4; p++) begin
      for (int x = 0; x < N; x++) begin
        ex = (p < 2) ? pat(x) : ~pat(x);
        if (p % 2 == 0) begin
          m[x] = ex;
        end else begin
          rd = m[x];
          if (fe && x == fa) rd = fp ? (rd | fm) : (rd & ~fm);
          if (rd != ex && !e_fail) begin
            e_fail = 1'b1;
            e_addr = x;
            e_data = int'(rd);
            if (STOP) e_lat = p * N + x + 2;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_faddr"}, 32'(fail_addr), 32'd0);
    chk({tag, "_fdata"}, 32'(fail_data), 32'd0);
    chk({tag, "_a"}, 32'(ram_bus.a), 32'd0);
    chk({tag, "_we"}, 32'(ram_bus.we), 32'd0);
    chk({tag, "_din"}, 32'(ram_bus.din), 32'd0);
  endtask

  // Leaves start high; the caller decides when to drop it
  task automatic start_test();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    k = cyc;
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_done", 32'(done), 32'd0);
    chk("acc_fail", 32'(fail), 32'd0);
    chk("acc_faddr", 32'(fail_addr), 32'd0);
    chk("acc_fdata", 32'(fail_data), 32'd0);
    chk("acc_din", 32'(ram_bus.din), 32'(pat(0)));
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 600; i++) begin
      if (done === 1'b1) begin
        lat = int'(cyc - k);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string tag, input bit fe, input int fa, input int fb,
                           input bit fp, input int repulse, input int hold);
    bit e_fail;
    int e_addr, e_data, e_lat, lat;
    logic [DW-1:0] fm;
    fm = DW'(1) << fb;
    f_en = fe; f_addr = AW'(fa); f_mask = fm; f_pol = fp;
    model(fe, fa, fm, fp, e_fail, e_addr, e_data, e_lat);
    start_test();
    repeat (hold) @(negedge clk);
    start = 1'b0;
    if (repulse > 0) begin
      repeat (repulse) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_fail"}, 32'(fail), 32'(e_fail));
    chk({tag, "_faddr"}, 32'(fail_addr), 32'(e_addr));
    chk({tag, "_fdata"}, 32'(fail_data), 32'(e_data));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_we"}, 32'(ram_bus.we), 32'd0);
    chk({tag, "_a"}, 32'(ram_bus.a), 32'd0);
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int x = 0; x < N; x++) if (mem[x] !== ~pat(x)) bad++;
    chk({tag, "_mem3"}, 32'(mem[3]), 32'h0000_00A6);
    chk({tag, "_membad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    for (int x = 0; x < N; x++) mem[x] = DW'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;

    // Fault-free, read-first, start held for a random stretch while busy
    wf_mode = 1'b0;
    run_check("rf_clean", 1'b0, 0, 0, 1'b0, 0, $urandom_range(5, 110));
    check_mem("rf_clean");

    // Fault-free, write-first, start re-pulsed while busy
    wf_mode = 1'b1;
    for (int x = 0; x < N; x++) mem[x] = DW'($urandom);
    run_check("wf_clean", 1'b0, 0, 0, 1'b0, $urandom_range(2, 100), 0);
    check_mem("wf_clean");

    // Word 17 bit 0 stuck-at-1, read-first
    wf_mode = 1'b0;
    run_check("sa1_17", 1'b1, 17, 0, 1'b1, 0, 0);

    // Random stuck bits; each run also proves start clears the previous failure
    for (int r = 0; r < 6; r++) begin
      wf_mode = 1'($urandom);
      run_check("rand_fault", 1'b1, int'($urandom_range(0, N - 1)), int'($urandom_range(0, DW - 1)),
                1'($urandom), (r % 2 == 1) ? int'($urandom_range(2, 20)) : 0, 0);
    end

    // Asynchronous reset in the middle of W1
    f_en = 1'b0;
    start_test();
    start = 1'b0;
    repeat (70) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_check("post_rst", 1'b0, 0, 0, 1'b0, 0, 0);
    check_mem("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
